// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester round-robin front end for a single SPI master.
// A winner's word is latched, the master is started with a one-cycle
// m_data_valid, and the received word is handed back to the owner on done.
// Optional feature: define SPI_ARB_TIMEOUT_EN to bound both wait states by
// TIMEOUT_CYCLES; an expired wait ends the transfer with done and err.
module spi_arbiter #(
    parameter int WORD_LENGTH    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [WORD_LENGTH-1:0] wdata0,
    input  logic [WORD_LENGTH-1:0] wdata1,
    output logic                   grant0,
    output logic                   grant1,
    output logic [WORD_LENGTH-1:0] rdata0,
    output logic [WORD_LENGTH-1:0] rdata1,
    output logic                   done0,
    output logic                   done1,
    output logic                   m_data_valid,
    output logic [WORD_LENGTH-1:0] m_wdata,
    input  logic [WORD_LENGTH-1:0] m_rdata,
    input  logic                   m_rdy,
    output logic                   owner,
    output logic                   busy,
    output logic                   err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BSY, WAIT_RDY, COMPLETE} state_t;

    state_t                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic [WORD_LENGTH-1:0] m_wdata_q, m_wdata_d;
    logic [WORD_LENGTH-1:0] rdata0_q, rdata0_d;
    logic [WORD_LENGTH-1:0] rdata1_q, rdata1_d;
    logic                   winner;
    logic                   tmo;

    // Tie goes to whoever was not served last; a lone request wins outright.
    assign winner = (req0 && req1) ? ~last_q : req1;

    // Next-state, ownership and data capture.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        m_wdata_d = m_wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        case (state_q)
            IDLE: begin
                if ((req0 || req1) && m_rdy) begin
                    owner_d   = winner;
                    m_wdata_d = winner ? wdata1 : wdata0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = WAIT_BSY;
            WAIT_BSY: begin
                if (!m_rdy)   state_d = WAIT_RDY;
                else if (tmo) state_d = COMPLETE;
            end
            WAIT_RDY: begin
                if (m_rdy) begin
                    if (owner_q) rdata1_d = m_rdata;
                    else         rdata0_d = m_rdata;
                    state_d = COMPLETE;
                end else if (tmo) begin
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; last-served resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            m_wdata_q <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            m_wdata_q <= m_wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign err = (state_q == COMPLETE) && to_q;

    // Wait-state age: restarts on every state change, counts while a wait state persists.
    // to_d flags a COMPLETE reached by expiry rather than by the master returning ready.
    always_comb begin
        cnt_d = '0;
        if ((state_q == WAIT_BSY || state_q == WAIT_RDY) && state_d == state_q)
            cnt_d = cnt_q + 1'b1;
        to_d = (state_d == COMPLETE) && tmo && !(state_q == WAIT_RDY && m_rdy);
    end

    // Timeout counter and expiry flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
`else
    logic unused_timeout;

    assign tmo            = 1'b0;
    assign err            = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    assign grant0       = (state_q == ISSUE) && !owner_q;
    assign grant1       = (state_q == ISSUE) && owner_q;
    assign m_data_valid = (state_q == ISSUE);
    assign done0        = (state_q == COMPLETE) && !owner_q;
    assign done1        = (state_q == COMPLETE) && owner_q;
    assign busy         = (state_q != IDLE);
    assign owner        = owner_q;
    assign m_wdata      = m_wdata_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter WORD_LENGTH, default 8, width of every data bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, cycles allowed per wait state before abort; used only with SPI_ARB_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0 / req1  input  1  requester 0/1 transfer request; held until its grant.
REQ-006 wdata0 / wdata1  input  WORD_LENGTH  requester 0/1 word to transmit; stable while its req is high.
REQ-007 grant0 / grant1  output  1  one-cycle pulse: request accepted, wdata latched.
REQ-008 rdata0 / rdata1  output  WORD_LENGTH  word received for requester 0/1; holds until that requester's next completion.
REQ-009 done0 / done1  output  1  one-cycle pulse: transfer for requester 0/1 finished, rdata valid.
REQ-010 m_data_valid  output  1  start pulse to SPI master data_valid.
REQ-011 m_wdata  output  WORD_LENGTH  word to SPI master WDATA.
REQ-012 m_rdata  input  WORD_LENGTH  SPI master RDATA.
REQ-013 m_rdy  input  1  SPI master status: 1 ready, 0 busy.
REQ-014 owner  output  1  index of requester currently owning the master; meaningful while busy=1.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 err  output  1  one-cycle timeout pulse; constant 0 without SPI_ARB_TIMEOUT_EN.

Function
REQ-017 States: IDLE, ISSUE, WAIT_BSY, WAIT_RDY, COMPLETE.
REQ-018 IDLE: with (req0|req1) and m_rdy=1, select winner, latch its wdata into m_wdata, set owner, go to ISSUE next cycle; otherwise stay.
REQ-019 IDLE with a request but m_rdy=0: stay in IDLE; no grant issued.
REQ-020 Arbitration round-robin: one request wins alone; with both asserted, the requester not served last wins.
REQ-021 ISSUE: exactly one cycle; m_data_valid=1 and grant<owner>=1 together; then WAIT_BSY.
REQ-022 WAIT_BSY: stay until m_rdy=0, then WAIT_RDY.
REQ-023 WAIT_RDY: stay until m_rdy=1; on that cycle capture m_rdata into rdata<owner>; then COMPLETE.
REQ-024 COMPLETE: exactly one cycle; done<owner>=1; record owner as last served; then IDLE.
REQ-025 Minimum latency req to grant: 1 cycle (req in IDLE at cycle N, grant at N+1).
REQ-026 A request held through COMPLETE is arbitrated again in the following IDLE cycle; no back-to-back grant without passing IDLE.
REQ-027 Requests changing during non-IDLE states are ignored; m_wdata is stable from ISSUE through COMPLETE.
REQ-028 Grant, done, m_data_valid and err never assert for more than one consecutive cycle, nor for both requesters in the same cycle.

Reset
REQ-029 rst=1 at any cycle, including mid-transfer, forces IDLE on the next edge, aborting the transfer without done.
REQ-030 Reset values: all outputs 0, m_wdata 0, rdata0/rdata1 0, last-served = requester 1 so requester 0 wins first tie.

Configuration
REQ-031 Macro SPI_ARB_TIMEOUT_EN: when defined, a counter cleared on entering WAIT_BSY and WAIT_RDY increments each cycle in those states.
REQ-032 With SPI_ARB_TIMEOUT_EN, counter reaching TIMEOUT_CYCLES-1 moves to COMPLETE: done<owner> and err pulse together; rdata<owner> unchanged; round-robin updated normally.
REQ-033 Without SPI_ARB_TIMEOUT_EN: no counter, wait states unbounded, err tied 0.

Verification
REQ-034 After reset, req0=1 wdata0=0xA5, m_rdy=1 -> grant0 and m_data_valid one cycle later, m_wdata=0xA5, owner=0.
REQ-035 Model master drops m_rdy 2 cycles, restores it with m_rdata=0x3C -> rdata0=0x3C, done0 one cycle after m_rdy rises.
REQ-036 req0 and req1 held together continuously -> grants alternate 0,1,0,1; each done precedes the next grant.
REQ-037 req1=1 while m_rdy=0 in IDLE -> no grant until m_rdy=1, then grant1 next cycle.
REQ-038 rst=1 during WAIT_RDY -> next cycle IDLE, busy=0, no done pulse, rdata unchanged at 0.
REQ-039 With SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, m_rdy stuck 1 after ISSUE -> err and done0 pulse 16 cycles after WAIT_BSY entry, rdata0 unchanged.
